// File: rtl/regfile_32x32.sv
// regfile_32x32 - 32 x 32-bit general-purpose register file for the single-cycle CPU.
// Two combinational read ports, one debug read port, one clocked write port.
// R0 has no storage and always reads as zero.
//
// Ports:
//   CLK    in   1   system clock, rising-edge writes
//   RST    in   1   asynchronous active-high reset, clears R1..R31
//   RA1    in   5   read address, port 1 (rs)
//   RA2    in   5   read address, port 2 (rt)
//   WA     in   5   write address (destination register number)
//   WD     in  32   write data
//   WE     in   1   write enable
//   RD1    out 32   read data, port 1
//   RD2    out 32   read data, port 2
//   DBG_A  in   5   debug read address
//   DBG_D  out 32   debug read data
//
// Build option:
//   REGFILE_BYPASS_EN  defined   -> write-first: a read of the register being
//                                   written this cycle returns WD combinationally.
//                      undefined -> read-old: reads return stored contents only.
module regfile_32x32 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  input  logic [4:0]  WA,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  input  logic [4:0]  DBG_A,
  output logic [31:0] DBG_D
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;

  // Storage for R1..R31 only; row 0 has no flops.
  logic [DEPTH-1:1][DATA_W-1:0] r_regs;
  logic [DEPTH-1:1]             w_row_sel;
  logic [DEPTH-1:0][DATA_W-1:0] w_rows;

  // One-hot write decode gated by WE; row 0 is never generated.
  always_comb begin
    w_row_sel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_row_sel[i] = WE && (WA == 5'(i));
    end
  end

  // Register update; async reset also blocks writes while RST is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_regs <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_row_sel[i]) begin
          r_regs[i] <= WD;
        end
      end
    end
  end

  // Full 32-row view with a constant-zero row 0 for the read muxes.
  assign w_rows = {r_regs, DATA_W'(0)};

  // Combinational read of one address, with optional same-cycle write bypass.
  function automatic logic [DATA_W-1:0] f_read(input logic [4:0] addr);
`ifdef REGFILE_BYPASS_EN
    // Bypass is suppressed under reset so every read port shows zero.
    if (!RST && WE && (WA != 5'd0) && (addr == WA)) begin
      return WD;
    end
`endif
    return w_rows[addr];
  endfunction

  assign RD1   = f_read(RA1);
  assign RD2   = f_read(RA2);
  assign DBG_D = f_read(DBG_A);

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32: directed sequences, a table of
// write/read vectors, and randomized traffic against an array model.
module tb_regfile_32x32;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RA1, RA2, WA, DBG_A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD1, RD2, DBG_D;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [8];

  regfile_32x32 dut (
    .CLK   (CLK),
    .RST   (RST),
    .RA1   (RA1),
    .RA2   (RA2),
    .WA    (WA),
    .WD    (WD),
    .WE    (WE),
    .RD1   (RD1),
    .RD2   (RD2),
    .DBG_A (DBG_A),
    .DBG_D (DBG_D)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write one register through the port and mirror it in the model.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; WA = a; WD = d;
    @(posedge CLK); #1;
    WE = 1'b0;
    if (a != 5'd0) mdl[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Expected combinational read from the model, given the current write inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mdl[a];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] exp_pre;

    tbl[0] = '{1'b1, 5'd17, 32'hDEADBEEF, 5'd17, 5'd17, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd17, 32'h00000000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 5'd30, 32'h80000001, 32'hA500001E};
    tbl[3] = '{1'b1, 5'd1,  32'h00000000, 5'd1,  5'd2,  32'h00000000, 32'hA5000002};
    tbl[4] = '{1'b1, 5'd1,  32'h00012345, 5'd1,  5'd1,  32'h00012345, 32'h00012345};
    tbl[5] = '{1'b1, 5'd1,  32'h00006789, 5'd1,  5'd0,  32'h00006789, 32'h00000000};
    tbl[6] = '{1'b0, 5'd2,  32'hFFFFFFFF, 5'd2,  5'd1,  32'hA5000002, 32'h00006789};
    tbl[7] = '{1'b1, 5'd16, 32'hCAFEF00D, 5'd16, 5'd17, 32'hCAFEF00D, 32'hDEADBEEF};

    clear_model();
    RST = 1'b1; WE = 1'b0; WA = 5'd0; WD = 32'h0;
    RA1 = 5'd5; RA2 = 5'd31; DBG_A = 5'd17;
    #2;
    chk("reset_rd1", RD1, 32'h0);
    chk("reset_rd2", RD2, 32'h0);
    chk("reset_dbg", DBG_D, 32'h0);
    #10 RST = 1'b0;
    @(posedge CLK); #1;

    // Preload then asynchronous reset mid-cycle.
    wr(5'd5, 32'h12345678);
    RA1 = 5'd5; #1;
    chk("preload_r5", RD1, 32'h12345678);
    #2 RST = 1'b1;
    #1 chk("async_reset_r5", RD1, 32'h0);
    #1 RST = 1'b0;
    clear_model();
    for (int i = 1; i < 32; i++) begin
      DBG_A = 5'(i); #1;
      chk("reset_sweep", DBG_D, 32'h0);
    end
    @(posedge CLK); #1;

    // R0 protection.
    wr(5'd0, 32'hFFFFFFFF);
    RA1 = 5'd0; #1;
    chk("r0_write_discard", RD1, 32'h0);

    // WE low for four edges leaves R3 untouched.
    WE = 1'b0; WA = 5'd3; WD = 32'h55555555;
    repeat (4) @(posedge CLK);
    #1 RA1 = 5'd3; #1;
    chk("we_low_r3", RD1, 32'h0);

    // Write and read back every register.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5000000 | 32'(i));
    for (int i = 1; i < 32; i++) begin
      RA1 = 5'(i); RA2 = 5'(i); DBG_A = 5'(i - 1); #1;
      v = 32'hA5000000 | 32'(i);
      chk("write_all_rd1", RD1, v);
      chk("write_all_rd2", RD2, v);
      chk("write_all_nbr", DBG_D, (i == 1) ? 32'h0 : (32'hA5000000 | 32'(i - 1)));
    end

    // Table of single-cycle write/read vectors.
    for (int k = 0; k < 8; k++) begin
      WE = tbl[k].we; WA = tbl[k].wa; WD = tbl[k].wd;
      @(posedge CLK); #1;
      WE = 1'b0;
      if (tbl[k].we && tbl[k].wa != 5'd0) mdl[tbl[k].wa] = tbl[k].wd;
      RA1 = tbl[k].ra1; RA2 = tbl[k].ra2; #1;
      chk($sformatf("tbl%0d_rd1", k), RD1, tbl[k].e1);
      chk($sformatf("tbl%0d_rd2", k), RD2, tbl[k].e2);
    end

    // Same-cycle read of the register being written.
    wr(5'd9, 32'h00000001);
    WE = 1'b1; WA = 5'd9; WD = 32'h00000002; RA1 = 5'd9; DBG_A = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h00000002;
`else
    exp_pre = 32'h00000001;
`endif
    chk("rw_same_pre_rd1", RD1, exp_pre);
    chk("rw_same_pre_dbg", DBG_D, exp_pre);
    @(posedge CLK); #1;
    WE = 1'b0; mdl[9] = 32'h00000002;
    chk("rw_same_post_rd1", RD1, 32'h00000002);

    // Write attempted while reset is held: register stays zero, reads show zero.
    wr(5'd7, 32'h0000AAAA);
    WE = 1'b1; WA = 5'd7; WD = 32'h00000077; RA1 = 5'd7; RA2 = 5'd9;
    RST = 1'b1; #1;
    chk("rst_hold_rd1", RD1, 32'h0);
    chk("rst_hold_rd2", RD2, 32'h0);
    @(posedge CLK); #2;
    RST = 1'b0; WE = 1'b0;
    clear_model();
    DBG_A = 5'd7; #1;
    chk("rst_write_blocked", DBG_D, 32'h0);
    @(posedge CLK); #1;

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      WE = 1'($urandom_range(0, 1));
      WA = 5'($urandom_range(0, 31));
      WD = $urandom;
      RA1 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
      RA2 = 5'($urandom_range(0, 31));
      DBG_A = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd1", RD1, exp_read(RA1, WE, WA, WD));
      chk("rand_rd2", RD2, exp_read(RA2, WE, WA, WD));
      chk("rand_dbg", DBG_D, exp_read(DBG_A, WE, WA, WD));
      @(posedge CLK);
      if (WE && WA != 5'd0) mdl[WA] = WD;
      #1;
    end
    WE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      DBG_A = 5'(i); #1;
      chk("final_sweep", DBG_D, mdl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_32x32.md
# regfile_32x32

General-purpose register file for the single-cycle CPU: 32 registers of 32 bits, two combinational read ports and one clocked write port. The 5-bit destination number chosen upstream (rt for I-type, rd for R-type) arrives on the write-address port. This block decodes it, gated by the write enable, into a one-hot row select and updates that register on the clock edge. Register 0 is hardwired to zero.

## Interface
Parameters: none. Width is 32 and depth is 32, both fixed by the ISA.

- CLK  input  1  system clock; all state updates on the rising edge
- RST  input  1  reset, asynchronous and active-high; clears every register to 0
- RA1  input  5  read address, port 1 (rs)
- RA2  input  5  read address, port 2 (rt)
- WA   input  5  write address (destination register number from the rt/rd select)
- WD   input  32  write data (ALU result or memory load data)
- WE   input  1  write enable, sampled on the rising edge of CLK
- RD1  output 32  read data, port 1
- RD2  output 32  read data, port 2
- DBG_A input 5  debug read address, used by the bench and the board display
- DBG_D output 32  debug read data

## Operation
- Storage: registers R1..R31, 32 bits each. R0 has no storage element.
- Write decode:
  - 5-to-32 one-hot decoder on WA, ANDed with WE.
  - Row 0 of the decoder output is ignored.
  - At most one row is active per cycle.
- Write: on the rising edge of CLK with WE=1 and WA≠0, R[WA] ← WD. All other registers hold.
- Write to WA=0 is silently discarded. R0 reads as 0 at all times.
- Reads:
  - RD1 = R[RA1], RD2 = R[RA2], DBG_D = R[DBG_A].
  - All reads are purely combinational from the current register contents.
  - Any read of address 0 returns 0x00000000.
- Both read ports may address the same register, or the register being written, in the same cycle. Behaviour when reading the register being written is set under Configuration.
- Reset:
  - RST=1 clears R1..R31 to 0 immediately, without waiting for a clock edge.
  - Writes are blocked for as long as RST is high.
  - If RST asserts on the same edge as a write, the register reads 0 afterwards.
- Reset values of the outputs follow from reset clearing all storage: RD1=RD2=DBG_D=0 for any address while RST is high.
- No undriven values: every register has a defined value after reset, so X never propagates to RD1/RD2.

## Timing
- Read latency: 0 cycles, combinational from RA*/DBG_A and the register state.
- Write latency: 1 edge. WD is visible on the read ports after the rising edge where WE=1.
- Setup: WA, WD and WE must be stable before the rising edge. They are not sampled at any other time.
- Back-to-back writes to the same register on consecutive cycles: the last written value wins. Each cycle is independent.
- Reset release:
  - RST deasserts asynchronously. The first write can take effect on the first rising edge with RST=0.
  - The bench deasserts RST away from the clock edge.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first):
  - If WE=1, WA≠0 and RAx==WA, then RDx = WD combinationally in that same cycle. The same rule applies to DBG_A/DBG_D.
  - Storage is still written on the edge.
- Undefined (read-old): reads always return stored contents, so a same-cycle read of the register being written returns its pre-edge value.
- R0 returns 0 in both builds, even if WE=1 and WA=0.

## Test plan
- Reset: preload R5=0x12345678, then pulse RST mid-cycle. Required: RD1 with RA1=5 reads 0x00000000 before the next edge, and all 31 registers read 0 via DBG_A sweep.
- R0 protection: WE=1, WA=0, WD=0xFFFFFFFF, one edge. Required: RD1 with RA1=0 reads 0x00000000.
- Write/read all:
  - Write R[i]=0xA5000000|i for i=1..31.
  - Required: RD1 and RD2 return the matching value for every i, and neighbouring registers are unchanged.
- Dual port, same address: RA1=RA2=17 after writing 0xDEADBEEF. Required: both ports read 0xDEADBEEF.
- Same-cycle read/write:
  - Setup: R9=0x00000001, then WE=1, WA=9, WD=0x00000002, RA1=9, checked before the edge.
  - Required with REGFILE_BYPASS_EN defined: RD1=0x00000002. Without it: RD1=0x00000001.
  - Both builds: RD1=0x00000002 after the edge.
- WE low: WE=0, WA=3, WD=0x55555555 over 4 edges. Required: R3 keeps its prior value of 0x00000000.
